// File: rtl/osc_sweep_driver.sv
// osc_sweep_driver
//   Sweeps every VEC_W-bit stimulus vector into a feedback-loop block under
//   test, holds each one for SETTLE_CYC cycles, then counts toggles on the
//   observed net over WATCH_CYC cycles. Vectors whose toggle count reaches
//   OSC_THRESH are reported one at a time over a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, starts a sweep when idle
//   abort      in   synchronous abort of a running sweep
//   vec_out    out  stimulus vector driven into the block under test
//   obs_in     in   observed net from the block under test (asynchronous)
//   busy       out  sweep in progress
//   done       out  one-cycle pulse on sweep completion (not on abort)
//   hit_valid  out  oscillating vector being reported
//   hit_vec    out  vector that oscillated, stable while hit_valid
//   hit_ready  in   consumer accepts the hit
//   osc_count  out  oscillating vectors found in the current/last sweep
module osc_sweep_driver #(
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WATCH_CYC  = 16,
  parameter int unsigned OSC_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec_out,
  input  logic             obs_in,
  output logic             busy,
  output logic             done,
  output logic             hit_valid,
  output logic [VEC_W-1:0] hit_vec,
  input  logic             hit_ready,
  output logic [VEC_W:0]   osc_count
);

  localparam int unsigned PH_MAX = (SETTLE_CYC > WATCH_CYC) ? SETTLE_CYC : WATCH_CYC;
  localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);
  localparam int unsigned TOG_W  = $clog2(WATCH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WATCH,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] ph_cnt;
  logic [TOG_W-1:0] tog_cnt;
  logic             obs_meta, obs_s, obs_q;
  logic             toggle;
  logic [31:0]      tog_sum;
  logic             settle_end, watch_end, is_hit, last_vec;

  // Two-flop synchronizer to obs_s, plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_meta <= 1'b0;
      obs_s    <= 1'b0;
      obs_q    <= 1'b0;
    end else begin
      obs_meta <= obs_in;
      obs_s    <= obs_meta;
      obs_q    <= obs_s;
    end
  end

  always_comb begin
    toggle     = obs_s ^ obs_q;
    // Include the toggle seen in the final watch cycle in the decision.
    tog_sum    = 32'(tog_cnt) + 32'(toggle);
    settle_end = (32'(ph_cnt) == SETTLE_CYC - 1);
    watch_end  = (32'(ph_cnt) == WATCH_CYC - 1);
    is_hit     = (tog_sum >= OSC_THRESH);
    last_vec   = (vec_out == '1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)           state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_WATCH;
      end
      S_WATCH: begin
        if (abort)          state_nxt = S_IDLE;
        else if (watch_end) begin
          if (is_hit)        state_nxt = S_REPORT;
          else if (last_vec) state_nxt = S_DONE;
          else               state_nxt = S_SETTLE;
        end
      end
      S_REPORT: begin
        if (abort)          state_nxt = S_IDLE;
        else if (hit_ready) state_nxt = last_vec ? S_DONE : S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_WATCH) || (state == S_REPORT);
    done      = (state == S_DONE);
    hit_valid = (state == S_REPORT);
  end

  // Datapath: phase/toggle counters, stimulus vector, hit capture, tally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt    <= '0;
      tog_cnt   <= '0;
      vec_out   <= '0;
      hit_vec   <= '0;
      osc_count <= '0;
    end else begin
      if ((state == S_SETTLE || state == S_WATCH) && state_nxt == state)
        ph_cnt <= ph_cnt + 1'b1;
      else
        ph_cnt <= '0;

      if (state == S_WATCH) begin
        if (toggle && 32'(tog_cnt) < WATCH_CYC)
          tog_cnt <= tog_cnt + 1'b1;
      end else begin
        tog_cnt <= '0;
      end

      if (state == S_IDLE && start) begin
        vec_out   <= '0;
        osc_count <= '0;
      end else begin
        // Advance only when leaving WATCH/REPORT toward the next vector.
        if ((state == S_WATCH || state == S_REPORT) && state_nxt == S_SETTLE)
          vec_out <= vec_out + 1'b1;
        if (state == S_WATCH && state_nxt == S_REPORT) begin
          hit_vec   <= vec_out;
          osc_count <= osc_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_osc_sweep_driver.sv
// Directed bench for osc_sweep_driver at default parameters.
module tb_osc_sweep_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       obs_in = 1'b0;
  logic       hit_ready = 1'b1;
  logic [7:0] vec_out;
  logic       busy, done, hit_valid;
  logic [7:0] hit_vec;
  logic [8:0] osc_count;

  int total = 0;
  int bad = 0;

  logic       tog_en = 1'b0;
  logic [7:0] tog_vec = '0;
  logic       gl_en = 1'b0;
  logic [7:0] gl_vec = '0;
  int         gl_n = 0;

  always #5 clk = ~clk;

  osc_sweep_driver #(
    .VEC_W(8),
    .SETTLE_CYC(4),
    .WATCH_CYC(16),
    .OSC_THRESH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .vec_out(vec_out),
    .obs_in(obs_in),
    .busy(busy),
    .done(done),
    .hit_valid(hit_valid),
    .hit_vec(hit_vec),
    .hit_ready(hit_ready),
    .osc_count(osc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed-net generator: continuous toggling on one vector, or a single
  // flip on the 12th cycle a chosen vector is applied (8 cycles into WATCH).
  initial begin
    forever begin
      @(negedge clk);
      if (tog_en && vec_out == tog_vec) obs_in = ~obs_in;
      if (gl_en && vec_out == gl_vec) begin
        gl_n++;
        if (gl_n == 12) obs_in = ~obs_in;
      end
    end
  end

  // Full sweep from a start pulse; cycle 0 is the cycle start is high.
  task automatic run_sweep(output int done_cyc, output int n_done, output int n_hit,
                           output logic [7:0] last_hit, output int vec_err,
                           output logic busy_at_done);
    done_cyc = -1; n_done = 0; n_hit = 0; last_hit = '0; vec_err = 0; busy_at_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 6000; c++) begin
      if (c <= 5120 && vec_out !== 8'((c - 1) / 20)) vec_err++;
      if (hit_valid) begin
        n_hit++;
        last_hit = hit_vec;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_hit(output int c_hit);
    c_hit = -1;
    for (int c = 1; c <= 300; c++) begin
      if (hit_valid) begin
        c_hit = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int         dc, nd, nh, ve, ch, errs;
    logic [7:0] lh;
    logic       bd;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_vec", 32'(vec_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_hit_valid", 32'(hit_valid), 0);
    check("rst_hit_vec", 32'(hit_vec), 0);
    check("rst_osc_count", 32'(osc_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // 1: no oscillation anywhere
    run_sweep(dc, nd, nh, lh, ve, bd);
    check("t1_done_cyc", 32'(dc), 5121);
    check("t1_done_cnt", 32'(nd), 1);
    check("t1_hits", 32'(nh), 0);
    check("t1_vec_seq", 32'(ve), 0);
    check("t1_busy_at_done", 32'(bd), 0);
    check("t1_osc_count", 32'(osc_count), 0);
    check("t1_vec_hold", 32'(vec_out), 255);
    check("t1_busy_after", 32'(busy), 0);

    // 2: oscillation on 0x5A only, hit_ready tied high
    tog_vec = 8'h5A; tog_en = 1'b1; hit_ready = 1'b1;
    run_sweep(dc, nd, nh, lh, ve, bd);
    tog_en = 1'b0;
    check("t2_done_cyc", 32'(dc), 5122);
    check("t2_done_cnt", 32'(nd), 1);
    check("t2_hits", 32'(nh), 1);
    check("t2_hit_vec", 32'(lh), 32'h5A);
    check("t2_osc_count", 32'(osc_count), 1);

    // 3: single glitch during 0x10 WATCH stays below threshold
    gl_vec = 8'h10; gl_n = 0; gl_en = 1'b1;
    run_sweep(dc, nd, nh, lh, ve, bd);
    gl_en = 1'b0;
    check("t3_glitch_seen", 32'(gl_n), 20);
    check("t3_done_cyc", 32'(dc), 5121);
    check("t3_hits", 32'(nh), 0);
    check("t3_osc_count", 32'(osc_count), 0);

    // 4: hit on 0x03 with back-pressure for 10 cycles
    tog_vec = 8'h03; tog_en = 1'b1; hit_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_hit(ch);
    check("t4_hit_cyc", 32'(ch), 81);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (hit_valid !== 1'b1 || hit_vec !== 8'h03 || vec_out !== 8'h03) errs++;
      @(negedge clk);
    end
    check("t4_stable", 32'(errs), 0);
    check("t4_valid_at_accept", 32'(hit_valid), 1);
    hit_ready = 1'b1;
    @(negedge clk);
    tog_en = 1'b0;
    check("t4_valid_drop", 32'(hit_valid), 0);
    check("t4_next_vec", 32'(vec_out), 4);
    check("t4_osc_count", 32'(osc_count), 1);
    check("t4_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_keep_cnt", 32'(osc_count), 1);

    // 5: second start ignored, abort during 0x20 WATCH
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 656; c++) begin
      if (c == 1) begin
        check("t5_clear_cnt", 32'(osc_count), 0);
        check("t5_busy", 32'(busy), 1);
      end
      if (c == 25) start = 1'b1;
      if (c == 26) start = 1'b0;
      if (c == 41) check("t5_vec_after_restart", 32'(vec_out), 2);
      if (c == 650) abort = 1'b1;
      if (c == 651) begin
        abort = 1'b0;
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_vec", 32'(vec_out), 32'h20);
        check("t5_abort_hit", 32'(hit_valid), 0);
      end
      if (done) nd++;
      @(negedge clk);
    end
    check("t5_no_done", 32'(nd), 0);

    // 6: asynchronous reset while reporting a hit on 0x02
    tog_vec = 8'h02; tog_en = 1'b1; hit_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_hit(ch);
    check("t6_hit_cyc", 32'(ch), 61);
    check("t6_pre_cnt", 32'(osc_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_vec", 32'(vec_out), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_hit_valid", 32'(hit_valid), 0);
    check("t6_rst_hit_vec", 32'(hit_vec), 0);
    check("t6_rst_osc_count", 32'(osc_count), 0);
    tog_en = 1'b0; hit_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_restart_vec", 32'(vec_out), 0);
    check("t6_restart_busy", 32'(busy), 1);
    check("t6_restart_cnt", 32'(osc_count), 0);
    repeat (20) @(negedge clk);
    check("t6_restart_vec1", 32'(vec_out), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osc_sweep_driver.md
Name: osc_sweep_driver

Overview:
- Sequential stimulus driver and oscillation monitor for the feedback-loop combinational blocks (combLogic family).
- Sweeps every input vector into the block under test and lets each one settle.
- Watches one observed net for toggling over a fixed window and reports each oscillating vector over a valid/ready handshake.
- Sits in the characterization harness between the test controller and the loop block.

Parameters:
- VEC_W, 8, width of the stimulus vector; sweep covers 0 .. 2^VEC_W-1.
- SETTLE_CYC, 4, cycles each vector is held before watching starts; must be >= 3 to cover the synchronizer.
- WATCH_CYC, 16, cycles the observed net is monitored per vector.
- OSC_THRESH, 2, toggle count within the watch window at or above which a vector is flagged oscillating.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  synchronous abort of a running sweep.
- vec_out  out  VEC_W  stimulus vector to the block under test.
- obs_in  in  1  observed net from the block under test; asynchronous.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes (not on abort).
- hit_valid  out  1  an oscillating vector is being reported.
- hit_vec  out  VEC_W  vector that oscillated; stable while hit_valid is high.
- hit_ready  in  1  consumer accepts the hit.
- osc_count  out  VEC_W+1  number of oscillating vectors in the current or last sweep.

Behaviour:
- Reset values: vec_out=0, busy=0, done=0, hit_valid=0, hit_vec=0, osc_count=0, FSM=IDLE, synchronizer flops=0.
- Reset mid-sweep aborts immediately with the same values.
- Synchronizer: obs_in passes through 2 flops to give obs_s, then 1 more flop to give obs_q.
  - A toggle is counted in any WATCH cycle where obs_s != obs_q.
  - The toggle counter saturates at WATCH_CYC.
- FSM states: IDLE, SETTLE, WATCH, REPORT, DONE.
- IDLE:
  - start=1 in cycle 0 → cycle 1: SETTLE, busy=1, vec_out=0, osc_count cleared to 0.
  - start while busy is ignored.
- SETTLE: holds for SETTLE_CYC cycles, then enters WATCH with the toggle counter cleared.
- WATCH: lasts WATCH_CYC cycles. At the end of the window:
  - toggles >= OSC_THRESH → REPORT: hit_valid=1, hit_vec=vec_out, osc_count+1.
  - otherwise, if vec_out is not the last vector → SETTLE with vec_out+1.
  - otherwise → DONE.
- REPORT:
  - hit_valid held until sampled with hit_ready=1.
  - vec_out is frozen during REPORT.
  - The cycle after acceptance: hit_valid=0, then next vector in SETTLE, or DONE after the last vector.
  - hit_ready is ignored outside REPORT.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Outputs persisting after done: vec_out holds the last vector and osc_count holds its value until the next start.
- abort=1 in SETTLE, WATCH or REPORT:
  - next cycle: IDLE, busy=0, hit_valid=0, no done pulse.
  - osc_count keeps its partial value.
  - abort has priority over hit_ready in the same cycle.
- Timing with no hits: vector k is applied on cycle 1 + k*(SETTLE_CYC+WATCH_CYC). For defaults the last WATCH ends at cycle 5120 and done is asserted on cycle 5121.
- osc_count maximum is 2^VEC_W and fits without overflow.

Test Plan:
- Constant obs_in=0, start at cycle 0:
  - vec_out steps 0..255, each held 20 cycles.
  - No hit_valid.
  - done=1 exactly at cycle 5121; osc_count=0; busy low from cycle 5121.
- obs_in toggling every cycle only while vec_out=0x5A, hit_ready tied 1:
  - exactly one hit with hit_vec=0x5A.
  - final osc_count=1.
  - done is delayed by 1 cycle relative to the no-hit case.
- Single glitch (one toggle) during vector 0x10's WATCH window:
  - below OSC_THRESH=2, so no hit and osc_count=0.
- Toggling on vector 0x03, hit_ready held low 10 cycles after hit_valid rises:
  - hit_valid, hit_vec=0x03 and vec_out=0x03 all stable for 10 cycles.
  - vec_out=0x04 appears 1 cycle after the accepting cycle.
- Second start pulse while busy, then abort during vector 0x20's WATCH:
  - the second start has no effect.
  - busy=0 next cycle, no done pulse, vec_out stays 0x20.
- rst_n pulled low mid-REPORT:
  - all outputs return to reset values asynchronously.
  - a subsequent start restarts the sweep from vector 0 with osc_count=0.
